// File: rtl/pio_poll_master.sv
// Avalon-MM initiator that services a switch PIO: it reads the data register on irq or poll
// timeout, re-arms the irq mask, and reports per-bit rise/fall events downstream.
module pio_poll_master #(
  parameter int DATA_W      = 10,
  parameter int POLL_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] cfg_mask,
  output logic [1:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              irq_in,
  output logic [DATA_W-1:0] sw_value,
  output logic              sw_changed,
  output logic [DATA_W-1:0] sw_rise,
  output logic [DATA_W-1:0] sw_fall,
  output logic              busy
);

  localparam int CNT_W = $clog2(POLL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(POLL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_READ    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_WMASK   = 2'd2,
    ST_IDLE    = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  poll_cnt, poll_cnt_next;
  logic              first_flag;
  logic [DATA_W-1:0] mask_shadow;
  logic [DATA_W-1:0] rd_data;
  logic              unused_readdata;

  assign rd_data         = avm_readdata[DATA_W-1:0];
  assign unused_readdata = ^avm_readdata[31:DATA_W];

  // Next-state and poll counter logic
  always_comb begin
    state_next    = state;
    poll_cnt_next = poll_cnt;
    case (state)
      ST_READ: begin
        state_next    = ST_CAPTURE;
        poll_cnt_next = CNT_RELOAD;
      end
      ST_CAPTURE: state_next = ST_WMASK;
      ST_WMASK:   state_next = ST_IDLE;
      ST_IDLE: begin
        if (irq_in || (poll_cnt == CNT_ZERO) || (cfg_mask != mask_shadow)) begin
          state_next = ST_READ;
        end else begin
          poll_cnt_next = poll_cnt - CNT_ONE;
        end
      end
      default: state_next = ST_READ;
    endcase
  end

  // State register and bus outputs, registered from the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_READ;
      poll_cnt       <= CNT_RELOAD;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= 2'd0;
      avm_writedata  <= 32'd0;
      busy           <= 1'b1;
    end else begin
      state          <= state_next;
      poll_cnt       <= poll_cnt_next;
      avm_chipselect <= (state_next == ST_READ) || (state_next == ST_WMASK);
      avm_write_n    <= (state_next != ST_WMASK);
      avm_address    <= (state_next == ST_WMASK) ? 2'd2 : 2'd0;
      busy           <= (state_next != ST_IDLE);
      // WMASK is only entered from CAPTURE, so the freshly read value is the new sw_value
      if (state == ST_CAPTURE) begin
        avm_writedata <= {{(32-DATA_W){1'b0}}, cfg_mask & ~rd_data};
      end else begin
        avm_writedata <= 32'd0;
      end
    end
  end

  // Switch capture and single-cycle event pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_value    <= {DATA_W{1'b0}};
      sw_changed  <= 1'b0;
      sw_rise     <= {DATA_W{1'b0}};
      sw_fall     <= {DATA_W{1'b0}};
      first_flag  <= 1'b1;
      mask_shadow <= {DATA_W{1'b0}};
    end else begin
      sw_changed <= 1'b0;
      sw_rise    <= {DATA_W{1'b0}};
      sw_fall    <= {DATA_W{1'b0}};
      if (state == ST_CAPTURE) begin
        sw_value    <= rd_data;
        // Shadow tracks exactly the cfg_mask that went into this mask write
        mask_shadow <= cfg_mask;
        if (first_flag) begin
          first_flag <= 1'b0;
        end else if (rd_data != sw_value) begin
          sw_changed <= 1'b1;
          sw_rise    <= rd_data & ~sw_value;
          sw_fall    <= ~rd_data & sw_value;
        end
      end
    end
  end

endmodule
